// File: rtl/btn_pkg.sv
// ============================================================================
// Module   : btn_pkg
// Brief    : Shared types and default constants for the button front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

   // Debounce FSM states
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } btn_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 1000;
   localparam int DEF_REPEAT_PERIOD   = 200;
   localparam int COUNT_W             = 8;

   // Largest of three values, used to size the shared timer width
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_sync.sv
// ============================================================================
// Module   : btn_sync
// Brief    : Two-flop synchronizer for an asynchronous pin. Both flops reset
//            to RESET_VAL so the pin reads as inactive straight after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_pulse_gen.sv
// ============================================================================
// Module   : button_pulse_gen
// Brief    : Synchronises and debounces a raw button, emits one-cycle press and
//            release pulses and keeps a wrapping 8-bit press count.
//            Optional auto-repeat is built when BTN_PULSE_AUTOREPEAT_EN is
//            defined; otherwise no repeat logic exists.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_pulse_gen
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int ACTIVE_LOW      = 0,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               button_raw,
   output logic               button_level,
   output logic               press_pulse,
   output logic               release_pulse,
   output logic [COUNT_W-1:0] press_count
);

   localparam int c_TIMER_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
   localparam logic c_ACT_LOW = (ACTIVE_LOW != 0);
   localparam logic [c_TIMER_W-1:0] c_DEB = c_TIMER_W'(DEBOUNCE_CYCLES);
   localparam logic [c_TIMER_W-1:0] c_ONE = c_TIMER_W'(1);

   logic                 w_sync_q;
   logic                 w_s;
   btn_state_t           r_state;
   btn_state_t           w_state_nxt;
   logic [c_TIMER_W-1:0] r_timer;
   logic [c_TIMER_W-1:0] w_timer_nxt;
   logic                 w_press_acc;
   logic                 w_release_acc;
   logic                 w_level_nxt;
   logic                 w_press_nxt;
   logic                 w_rep_fire;
   logic                 r_level;
   logic                 r_press;
   logic                 r_release;
   logic [COUNT_W-1:0]   r_count;

   // Synchronizer idles at the pin's inactive level
   btn_sync #(
      .RESET_VAL (c_ACT_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (button_raw),
      .q   (w_sync_q)
   );

   assign w_s = w_sync_q ^ c_ACT_LOW;

   // State and debounce timer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // Next-state: a level change must be seen continuously until the timer
   // reaches DEBOUNCE_CYCLES; any bounce returns to the stable state
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      case (r_state)
         IDLE: begin
            if (w_s) begin
               w_state_nxt = PRESS_CHK;
               w_timer_nxt = c_ONE;
            end else begin
               w_timer_nxt = '0;
            end
         end
         PRESS_CHK: begin
            if (!w_s) begin
               w_state_nxt = IDLE;
               w_timer_nxt = '0;
            end else if (r_timer == c_DEB) begin
               w_state_nxt = HELD;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + c_ONE;
            end
         end
         HELD: begin
            if (!w_s) begin
               w_state_nxt = REL_CHK;
               w_timer_nxt = c_ONE;
            end else begin
               w_timer_nxt = '0;
            end
         end
         REL_CHK: begin
            if (w_s) begin
               w_state_nxt = HELD;
               w_timer_nxt = '0;
            end else if (r_timer == c_DEB) begin
               w_state_nxt = IDLE;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + c_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   // Output decode from the transition about to be taken
   always_comb begin
      w_press_acc   = (r_state == PRESS_CHK) && (w_state_nxt == HELD);
      w_release_acc = (r_state == REL_CHK) && (w_state_nxt == IDLE);
      w_level_nxt   = (w_state_nxt == HELD) || (w_state_nxt == REL_CHK);
      w_press_nxt   = w_press_acc | w_rep_fire;
   end

`ifdef BTN_PULSE_AUTOREPEAT_EN
   localparam logic [c_TIMER_W-1:0] c_REP_DELAY  = c_TIMER_W'(REPEAT_DELAY);
   localparam logic [c_TIMER_W-1:0] c_REP_PERIOD = c_TIMER_W'(REPEAT_PERIOD);

   logic [c_TIMER_W-1:0] r_rep_cnt;
   logic                 r_rep_first;
   logic [c_TIMER_W-1:0] w_rep_inc;
   logic [c_TIMER_W-1:0] w_rep_target;
   logic                 w_rep_run;

   assign w_rep_inc    = r_rep_cnt + c_ONE;
   assign w_rep_target = r_rep_first ? c_REP_DELAY : c_REP_PERIOD;
   assign w_rep_run    = (r_state == HELD) && w_s;
   assign w_rep_fire   = w_rep_run && (w_rep_inc == w_rep_target);

   // Repeat timer: counts only while staying HELD, holds in REL_CHK,
   // cleared whenever the button is not (about to be) held
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (!w_level_nxt) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (w_rep_run) begin
         if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
         end else begin
            r_rep_cnt   <= w_rep_inc;
         end
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

   // Registered outputs and wrapping press counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_count   <= '0;
      end else begin
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_acc;
         r_count   <= r_count + {{(COUNT_W-1){1'b0}}, w_press_nxt};
      end
   end

   assign button_level  = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign press_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_button_pulse_gen.sv
// ============================================================================
// Module   : tb_button_pulse_gen
// Brief    : Scoreboard bench for button_pulse_gen (DEBOUNCE_CYCLES=4).
//            Define BTN_PULSE_AUTOREPEAT_EN to exercise auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_pulse_gen;

   localparam int DEB  = 4;
   localparam int LAT  = 2 + DEB;
   localparam int RDLY = 20;
   localparam int RPER = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       button_raw;
   logic       button_level;
   logic       press_pulse;
   logic       release_pulse;
   logic [7:0] press_count;

   button_pulse_gen #(
      .DEBOUNCE_CYCLES (DEB),
      .ACTIVE_LOW      (0),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .button_raw    (button_raw),
      .button_level  (button_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .press_count   (press_count)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge k, cyc == k
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         rel;
      int         at;
      logic [7:0] cnt;
   } ev_t;

   ev_t        q[$];
   int         n_vec     = 0;
   int         n_err     = 0;
   int         n_press   = 0;
   logic [7:0] exp_count = 8'd0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_press(input int at);
      exp_count = exp_count + 8'd1;
      q.push_back('{1'b0, at, exp_count});
   endtask

   task automatic expect_release(input int at);
      q.push_back('{1'b1, at, exp_count});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      step(n);
      rst = 1'b0;
      exp_count = 8'd0;
   endtask

   task automatic press_release(input int hold_cyc);
      int e;
      button_raw = 1'b1;
      e = cyc + 1;
      expect_press(e + LAT);
      step(hold_cyc);
      button_raw = 1'b0;
      e = cyc + 1;
      expect_release(e + LAT);
      step(LAT + 3);
   endtask

   // Monitor: every pulse the DUT presents is matched against the queue head
   always @(negedge clk) begin
      ev_t e;
      if (press_pulse && release_pulse) begin
         n_vec++;
         n_err++;
         $display("FAIL both_pulses: press and release high together at edge %0d", cyc);
      end
      if (press_pulse || release_pulse) begin
         if (press_pulse) n_press++;
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: press=%0b release=%0b at edge %0d, none expected",
                     press_pulse, release_pulse, cyc);
         end else begin
            e = q.pop_front();
            chk("pulse_kind(release=1)", int'(release_pulse), int'(e.rel));
            chk("pulse_edge", cyc, e.at);
            chk("pulse_count", int'(press_count), int'(e.cnt));
            chk("pulse_level", int'(button_level), int'(!e.rel));
         end
      end
   end

   initial begin
      int e;
      int p;
      int n_start;

      button_raw = 1'b0;
      rst        = 1'b1;
      step(3);
      chk("reset_level", int'(button_level), 0);
      chk("reset_press", int'(press_pulse), 0);
      chk("reset_release", int'(release_pulse), 0);
      chk("reset_count", int'(press_count), 0);
      rst = 1'b0;
      exp_count = 8'd0;

      // 1. Clean press sampled at edge 10, release sampled at edge 40
      while (cyc < 9) step(1);
      button_raw = 1'b1;
      expect_press(16);
      while (cyc < 39) step(1);
      chk("t1_level_held", int'(button_level), 1);
      button_raw = 1'b0;
      expect_release(46);
      step(LAT + 3);
      chk("t1_count", int'(press_count), 1);
      chk("t1_level_released", int'(button_level), 0);

      // 2. Bounce: toggle every 2 cycles for 12 cycles, then stay high
      for (int i = 0; i < 12; i++) begin
         button_raw = ((i / 2) % 2) == 0;
         step(1);
      end
      button_raw = 1'b1;
      e = cyc + 1;
      expect_press(e + LAT);
      step(LAT + 4);
      chk("t2_level", int'(button_level), 1);
      button_raw = 1'b0;
      e = cyc + 1;
      expect_release(e + LAT);
      step(LAT + 3);

      // 3. Glitch shorter than the debounce window
      button_raw = 1'b1;
      step(3);
      button_raw = 1'b0;
      step(12);
      chk("t3_level", int'(button_level), 0);
      chk("t3_count", int'(press_count), 2);

      // 4. Counter wrap: 256 presses from reset return the count to 0
      do_reset(2);
      n_start = n_press;
      for (int i = 0; i < 256; i++) press_release(LAT + 2);
      chk("t4_count_wrapped", int'(press_count), 0);
      chk("t4_press_pulses", n_press - n_start, 256);

      // 5. Reset while in PRESS_CHK
      press_release(LAT + 2);
      button_raw = 1'b1;
      step(3);
      rst = 1'b1;
      step(1);
      chk("t5_rst_level", int'(button_level), 0);
      chk("t5_rst_press", int'(press_pulse), 0);
      chk("t5_rst_count", int'(press_count), 0);
      rst = 1'b0;
      exp_count = 8'd0;
      e = cyc + 1;
      expect_press(e + LAT);
      step(LAT + 3);
      chk("t5_level", int'(button_level), 1);
      button_raw = 1'b0;
      e = cyc + 1;
      expect_release(e + LAT);
      step(LAT + 3);

      // 6. Long hold: auto-repeat when built in, single press otherwise
      do_reset(2);
      button_raw = 1'b1;
      e = cyc + 1;
      p = e + LAT;
      expect_press(p);
`ifdef BTN_PULSE_AUTOREPEAT_EN
      for (int k = RDLY; k <= RDLY + 4 * RPER; k += RPER) expect_press(p + k);
`endif
      while (cyc < p + 40) step(1);
      button_raw = 1'b0;
      e = cyc + 1;
      expect_release(e + LAT);
      step(LAT + 3);
`ifdef BTN_PULSE_AUTOREPEAT_EN
      chk("t6_count", int'(press_count), 6);
`else
      chk("t6_count", int'(press_count), 1);
`endif

      step(10);
      chk("missing_events", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
